acc_shift_ctrl: RTL and testbench

//  Sequencer for accumulator shift orders (R/L). Decodes shift count from order n-field,

---
 rtl/acc_shift_ctrl.sv | 118 +++++++++++
 tb/tb_acc_shift_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_shift_ctrl.sv
// Accumulator shift-order sequencer: decodes the shift count from the n-field and steps
// g5 with c7/c8 once per word tick. Optional abort input under macro ACC_SHIFT_ABORT_EN.
module acc_shift_ctrl #(
  parameter int FIELD_W = 11,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               dir_l,
  input  logic [FIELD_W-1:0] nfield,
  input  logic               tick,
`ifdef ACC_SHIFT_ABORT_EN
  input  logic               abort,
`endif
  output logic               ready,
  output logic               busy,
  output logic               g5,
  output logic               c7,
  output logic               c8,
  output logic               done,
  output logic [CNT_W-1:0]   remaining,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               done_q;
  logic               abort_i;

`ifdef ACC_SHIFT_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Lowest set bit wins: scanning downward lets the lowest index overwrite higher ones.
  function automatic logic [CNT_W-1:0] decode(input logic [FIELD_W-1:0] nf);
    logic [CNT_W-1:0] r;
    r = '0;
    for (int i = FIELD_W - 1; i >= 0; i--) begin
      if (nf[i]) r = CNT_W'(i + 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = dir_l;
          cnt_d   = decode(nfield);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort_i) begin
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
          rem_d   = cnt_q;
          state_d = (cnt_q == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort_i) begin
          rem_d   = '0;
          state_d = S_DONE;
        end else if (tick && rem_q != '0) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      done_q  <= (state_d == S_DONE);
    end
  end

  // Direction lines and the gate derive from registered state, so reset drops them at once.
  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign g5        = (state_q == S_SHIFT) && tick && (rem_q != '0) && !abort_i;
  assign c7        = busy && !dir_q;
  assign c8        = busy && dir_q;
  assign done      = done_q;
  assign remaining = rem_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_acc_shift_ctrl.sv
// Directed bench for acc_shift_ctrl: table of shift orders plus reset and abort sequences.
module tb_acc_shift_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        dir_l;
  logic [10:0] nfield;
  logic        tick;
`ifdef ACC_SHIFT_ABORT_EN
  logic        abort;
`endif
  logic        ready, busy, g5, c7, c8, done;
  logic [3:0]  remaining;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  acc_shift_ctrl #(.FIELD_W(11), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir_l     (dir_l),
    .nfield    (nfield),
    .tick      (tick),
`ifdef ACC_SHIFT_ABORT_EN
    .abort     (abort),
`endif
    .ready     (ready),
    .busy      (busy),
    .g5        (g5),
    .c7        (c7),
    .c8        (c8),
    .done      (done),
    .remaining (remaining),
    .state_dbg (state_dbg)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dir;
    logic [10:0] nf;
    int          period;
    int          n1;
    int          n2;
    int          exp_pulses;
    int          exp_done_k;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle k is the k-th clock period after the edge that accepts start.
  task automatic run_seq(input vec_t v, output int pulses, output int done_k, output int dones,
                         output int dir_bad, output int g5_bad, output int rem2,
                         output int rem_done, output int ready_after, output int busy_after);
    pulses = 0; done_k = -1; dones = 0; dir_bad = 0; g5_bad = 0;
    rem2 = -1; rem_done = -1; ready_after = 0; busy_after = 1;
    @(negedge clk);
    start = 1'b1; dir_l = v.dir; nfield = v.nf; tick = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      start = (k == v.n1) || (k == v.n2);
      if (start) begin
        nfield = 11'h001;
        dir_l  = ~v.dir;
      end else begin
        dir_l  = v.dir;
      end
      tick = ((k % v.period) == 0);
      #2;
      if (g5) pulses++;
      if (g5 && !tick) g5_bad++;
      if (busy ? (c7 !== ~v.dir || c8 !== v.dir) : (c7 || c8)) dir_bad++;
      if (k == 2) rem2 = int'(remaining);
      if (done) begin
        dones++;
        if (done_k < 0) begin
          done_k   = k;
          rem_done = int'(remaining);
        end
      end
      if (done_k > 0 && k == done_k + 1) begin
        ready_after = int'(ready);
        busy_after  = int'(busy);
        break;
      end
    end
    start = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    int pulses, done_k, dones, dir_bad, g5_bad, rem2, rem_done, ready_after, busy_after;
    run_seq(v, pulses, done_k, dones, dir_bad, g5_bad, rem2, rem_done, ready_after, busy_after);
    check({tag, " g5 pulses"}, pulses, v.exp_pulses);
    check({tag, " done cycle"}, done_k, v.exp_done_k);
    check({tag, " done count"}, dones, 1);
    check({tag, " c7/c8 errors"}, dir_bad, 0);
    check({tag, " g5 off tick"}, g5_bad, 0);
    check({tag, " remaining at load"}, rem2, v.exp_pulses);
    check({tag, " remaining at done"}, rem_done, 0);
    check({tag, " ready after done"}, ready_after, 1);
    check({tag, " busy after done"}, busy_after, 0);
  endtask

  initial begin
    int pulses;
    int done_seen;

    // {dir, nfield, tick period, noise-start cycles, expected pulses, expected done cycle}
    vecs[0] = '{1'b0, 11'b000_0000_0001, 1, 0, 0, 1, 3};
    vecs[1] = '{1'b1, 11'b000_0001_0000, 3, 0, 0, 5, 16};
    vecs[2] = '{1'b0, 11'b000_0000_0000, 1, 0, 0, 0, 2};
    vecs[3] = '{1'b1, 11'b100_0000_0000, 1, 0, 0, 11, 13};
    vecs[4] = '{1'b0, 11'b000_0001_0000, 1, 3, 7, 5, 7};
    vecs[5] = '{1'b1, 11'b101_0000_0100, 2, 0, 0, 3, 7};

    rst_n = 1'b0; start = 1'b0; dir_l = 1'b0; nfield = '0; tick = 1'b0;
`ifdef ACC_SHIFT_ABORT_EN
    abort = 1'b0;
`endif
    #3;
    check("reset ready", int'(ready), 1);
    check("reset busy", int'(busy), 0);
    check("reset g5", int'(g5), 0);
    check("reset c7c8", int'({c7, c8}), 0);
    check("reset done", int'(done), 0);
    check("reset remaining", int'(remaining), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_and_check($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    // Reset after 2 of 5 steps: outputs drop immediately, no done pulse.
    pulses = 0;
    start = 1'b1; dir_l = 1'b1; nfield = 11'b000_0001_0000; tick = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      tick  = (k >= 2);
      #2;
      if (g5) pulses++;
    end
    check("midreset pulses before", pulses, 2);
    @(negedge clk);
    tick  = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midreset busy", int'(busy), 0);
    check("midreset g5", int'(g5), 0);
    check("midreset c7c8", int'({c7, c8}), 0);
    check("midreset ready", int'(ready), 1);
    check("midreset remaining", int'(remaining), 0);
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      if (done) done_seen++;
    end
    tick  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    if (done) done_seen++;
    check("midreset no done", done_seen, 0);
    run_and_check("after reset", vecs[0]);
    @(negedge clk);

`ifdef ACC_SHIFT_ABORT_EN
    // Abort after 3 of 8 steps.
    pulses = 0;
    start = 1'b1; dir_l = 1'b0; nfield = 11'b000_1000_0000; tick = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      tick  = (k >= 2);
      #2;
      if (g5) pulses++;
    end
    check("abort pulses before", pulses, 3);
    @(negedge clk);
    abort = 1'b1;
    tick  = 1'b1;
    #2;
    check("abort g5 masked", int'(g5), 0);
    @(negedge clk);
    abort = 1'b0;
    #2;
    check("abort done", int'(done), 1);
    check("abort g5 after", int'(g5), 0);
    check("abort remaining", int'(remaining), 0);
    @(negedge clk);
    tick = 1'b0;
    #2;
    check("abort ready", int'(ready), 1);
    check("abort done drop", int'(done), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
